// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage.
//   - ALU operation codes driven on ALUControlE
//   - branch condition codes driven on BrCondE
//   - forwarding select codes driven on ForwardA_E / ForwardB_E
//   - state type of the iterative multiplier FSM
package exec_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_NE = 2'b01;
    localparam logic [1:0] BR_LT = 2'b10;
    localparam logic [1:0] BR_GE = 2'b11;

    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_RESW    = 2'b01;
    localparam logic [1:0] FWD_ALUM    = 2'b10;
    localparam logic [1:0] FWD_REG_ALT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/execute_stage_mc_seq_multiplier.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst    clock / synchronous active-high reset
//   i_start     begin a multiply (only honoured in IDLE); operands sampled then
//   i_abort     drop the multiply in MUL or DONE, return to IDLE next edge
//   i_hold      downstream stall: keeps the FSM in DONE
//   i_a, i_b    multiplicand / multiplier
//   o_busy      upstream stall request
//   o_done      product is final (DONE state)
//   o_product   low DATA_W bits of i_a * i_b
//   o_state     FSM state, for observation
// Handshake: o_busy is combinational; while it is high the producer must keep
// the instruction in E unchanged. The product is consumed on the DONE edge
// where i_hold is low, which is also the first cycle o_busy is low.
module seq_multiplier
    import exec_pkg::*;
#(
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_hold,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_product,
    output mul_state_t        o_state
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    mul_state_t        r_state;
    mul_state_t        w_state_next;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = i_start;
                if (i_start) begin
                    w_state_next = ST_MUL;
                end
            end
            ST_MUL: begin
                o_busy = 1'b1;
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                end else if (r_count == CNT_W'(1)) begin
                    // This edge performs the last of the DATA_W steps.
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done = 1'b1;
                o_busy = i_hold;
                if (i_abort || !i_hold) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Shift-add datapath: the multiplicand moves left, the multiplier moves
    // right, and bit 0 of the multiplier gates the accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mcand  <= i_a;
                        r_mplier <= i_b;
                        r_acc    <= '0;
                        r_count  <= CNT_W'(DATA_W);
                    end
                end
                ST_MUL: begin
                    if (!i_abort) begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_product = r_acc;
    assign o_state   = r_state;

endmodule

// File: rtl/execute_stage_mc.sv
// Execute stage with operand forwarding, ALU, branch resolution, an iterative
// multiplier and the E/M pipeline register.
// Ports:
//   clk, rst                         clock / synchronous active-high reset
//   ValidE, RegWriteE, MemWriteE,
//   ResultSrcE, BranchE, BrCondE,
//   MulE, ALUSrcE, ALUControlE       decoded controls of the instruction in E
//   RD1_E, RD2_E, Imm_Ext_E,
//   PCE, PCPlus4E, RD_E, AuxE        operands, PC values, destination, sideband
//   ResultW                          writeback value for forwarding
//   ForwardA_E, ForwardB_E           forwarding selects
//   HoldM, FlushE                    hazard-unit hold of E/M, kill of E
//   StallE                           multiplier busy, hold E upstream
//   PCSrcE, PCTargetE                branch taken / branch target
//   ValidM..AuxM                     E/M register contents
// Handshake: StallE is a combinational ready-low; while it is high the
// instruction in E must be presented unchanged. A multiply leaves E on the
// edge where StallE is low.
module execute_stage_mc
    import exec_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int REG_AW = 5,
    parameter int AUX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ValidE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              ResultSrcE,
    input  logic              BranchE,
    input  logic [1:0]        BrCondE,
    input  logic              MulE,
    input  logic              ALUSrcE,
    input  logic [2:0]        ALUControlE,
    input  logic [DATA_W-1:0] RD1_E,
    input  logic [DATA_W-1:0] RD2_E,
    input  logic [DATA_W-1:0] Imm_Ext_E,
    input  logic [DATA_W-1:0] PCE,
    input  logic [DATA_W-1:0] PCPlus4E,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [AUX_W-1:0]  AuxE,
    input  logic [1:0]        ForwardA_E,
    input  logic [1:0]        ForwardB_E,
    input  logic              HoldM,
    input  logic              FlushE,
    output logic              StallE,
    output logic              PCSrcE,
    output logic [DATA_W-1:0] PCTargetE,
    output logic              ValidM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              ResultSrcM,
    output logic [REG_AW-1:0] RD_M,
    output logic [DATA_W-1:0] ALU_ResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] PCPlus4M,
    output logic [AUX_W-1:0]  AuxM
);

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_bf;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;
    logic [4:0]        w_shamt;
    logic              w_lt_ab;
    logic              w_cond;
    logic              w_mul_start;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_product;
    mul_state_t        w_state;
    logic              w_bubble;

    // Controls of the multiply, captured on its start edge.
    logic              r_cap_regwrite;
    logic              r_cap_memwrite;
    logic              r_cap_resultsrc;
    logic [REG_AW-1:0] r_cap_rd;
    logic [AUX_W-1:0]  r_cap_aux;
    logic [DATA_W-1:0] r_cap_pcplus4;
    logic [DATA_W-1:0] r_cap_wdata;

    always_comb begin
        w_a = RD1_E;
        case (ForwardA_E)
            FWD_RESW: w_a = ResultW;
            FWD_ALUM: w_a = ALU_ResultM;
            default:  w_a = RD1_E;
        endcase
    end

    always_comb begin
        w_bf = RD2_E;
        case (ForwardB_E)
            FWD_RESW: w_bf = ResultW;
            FWD_ALUM: w_bf = ALU_ResultM;
            default:  w_bf = RD2_E;
        endcase
    end

    assign w_b     = ALUSrcE ? Imm_Ext_E : w_bf;
    assign w_shamt = w_b[4:0];
    assign w_lt_ab = $signed(w_a) < $signed(w_b);

    always_comb begin
        w_alu = '0;
        case (ALUControlE)
            ALU_ADD: w_alu = w_a + w_b;
            ALU_SUB: w_alu = w_a - w_b;
            ALU_AND: w_alu = w_a & w_b;
            ALU_OR:  w_alu = w_a | w_b;
            ALU_XOR: w_alu = w_a ^ w_b;
            ALU_SLT: w_alu = {{(DATA_W-1){1'b0}}, w_lt_ab};
            ALU_SLL: w_alu = w_a << w_shamt;
            ALU_SRL: w_alu = w_a >> w_shamt;
            default: w_alu = '0;
        endcase
    end

    // Branch compare always uses the forwarded register operand, never the
    // immediate.
    always_comb begin
        w_cond = 1'b0;
        case (BrCondE)
            BR_EQ:   w_cond = (w_a == w_bf);
            BR_NE:   w_cond = (w_a != w_bf);
            BR_LT:   w_cond = $signed(w_a) < $signed(w_bf);
            BR_GE:   w_cond = !($signed(w_a) < $signed(w_bf));
            default: w_cond = 1'b0;
        endcase
    end

    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = ValidE & BranchE & w_cond & !FlushE & (w_state == ST_IDLE);

    assign w_mul_start = ValidE & MulE & !FlushE & (w_state == ST_IDLE);

    seq_multiplier #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_abort   (FlushE),
        .i_hold    (HoldM),
        .i_a       (w_a),
        .i_b       (w_bf),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product),
        .o_state   (w_state)
    );

    assign StallE = w_mul_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_regwrite  <= 1'b0;
            r_cap_memwrite  <= 1'b0;
            r_cap_resultsrc <= 1'b0;
            r_cap_rd        <= '0;
            r_cap_aux       <= '0;
            r_cap_pcplus4   <= '0;
            r_cap_wdata     <= '0;
        end else if (w_mul_start) begin
            r_cap_regwrite  <= RegWriteE;
            r_cap_memwrite  <= MemWriteE;
            r_cap_resultsrc <= ResultSrcE;
            r_cap_rd        <= RD_E;
            r_cap_aux       <= AuxE;
            r_cap_pcplus4   <= PCPlus4E;
            r_cap_wdata     <= w_bf;
        end
    end

    // The start cycle of a multiply also bubbles: the product is not ready.
    assign w_bubble = FlushE | !ValidE | (w_state == ST_MUL) | w_mul_start;

    // E/M register: reset, then hold, then bubble, then load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ValidM      <= 1'b0;
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            ALU_ResultM <= '0;
            WriteDataM  <= '0;
            PCPlus4M    <= '0;
            AuxM        <= '0;
        end else if (!HoldM) begin
            if (w_bubble) begin
                // Data fields keep their old value; only the controls die.
                ValidM    <= 1'b0;
                RegWriteM <= 1'b0;
                MemWriteM <= 1'b0;
            end else if (w_mul_done) begin
                ValidM      <= 1'b1;
                RegWriteM   <= r_cap_regwrite;
                MemWriteM   <= r_cap_memwrite;
                ResultSrcM  <= r_cap_resultsrc;
                RD_M        <= r_cap_rd;
                ALU_ResultM <= w_product;
                WriteDataM  <= r_cap_wdata;
                PCPlus4M    <= r_cap_pcplus4;
                AuxM        <= r_cap_aux;
            end else begin
                ValidM      <= 1'b1;
                RegWriteM   <= RegWriteE;
                MemWriteM   <= MemWriteE;
                ResultSrcM  <= ResultSrcE;
                RD_M        <= RD_E;
                ALU_ResultM <= w_alu;
                WriteDataM  <= w_bf;
                PCPlus4M    <= PCPlus4E;
                AuxM        <= AuxE;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage_mc.sv
module tb_execute_stage_mc;

    localparam int W = 18;

    typedef struct packed {
        logic        regw;
        logic        memw;
        logic        rsrc;
        logic [4:0]  rd;
        logic [17:0] alu;
        logic [17:0] wdata;
        logic [17:0] pc4;
        logic [1:0]  aux;
    } m_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ValidE = 0, RegWriteE = 0, MemWriteE = 0, ResultSrcE = 0;
    logic          BranchE = 0, MulE = 0, ALUSrcE = 0, HoldM = 0, FlushE = 0;
    logic [1:0]    BrCondE = 0, ForwardA_E = 0, ForwardB_E = 0, AuxE = 0;
    logic [2:0]    ALUControlE = 0;
    logic [W-1:0]  RD1_E = 0, RD2_E = 0, Imm_Ext_E = 0, PCE = 0, PCPlus4E = 0, ResultW = 0;
    logic [4:0]    RD_E = 0;
    logic          StallE, PCSrcE, ValidM, RegWriteM, MemWriteM, ResultSrcM;
    logic [W-1:0]  PCTargetE, ALU_ResultM, WriteDataM, PCPlus4M;
    logic [4:0]    RD_M;
    logic [1:0]    AuxM;

    int   n_checks = 0;
    int   n_errors = 0;
    m_t   exp_q[$];
    logic [W-1:0] m_alu = 0;
    bit   m_fresh = 0;

    execute_stage_mc #(.DATA_W(W), .REG_AW(5), .AUX_W(2)) dut (
        .clk(clk), .rst(rst), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE),
        .BrCondE(BrCondE), .MulE(MulE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .ResultW(ResultW), .RD_E(RD_E), .AuxE(AuxE),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .HoldM(HoldM),
        .FlushE(FlushE), .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M), .ALU_ResultM(ALU_ResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .AuxM(AuxM)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sx(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    function automatic logic [W-1:0] fwd_ref(input logic [W-1:0] reg_v, input logic [1:0] sel);
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return m_alu;
        return reg_v;
    endfunction

    function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint t;
        int sh;
        sh = int'(b) % 32;
        case (op)
            3'd0: t = longint'(a) + longint'(b);
            3'd1: t = longint'(a) - longint'(b);
            3'd2: t = longint'(a & b);
            3'd3: t = longint'(a | b);
            3'd4: t = longint'(a ^ b);
            3'd5: t = (sx(a) < sx(b)) ? 1 : 0;
            3'd6: t = longint'(a) << sh;
            default: t = longint'(a) >> sh;
        endcase
        return t[W-1:0];
    endfunction

    function automatic bit br_ref(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            2'd0: return a == b;
            2'd1: return a != b;
            2'd2: return sx(a) < sx(b);
            default: return sx(a) >= sx(b);
        endcase
    endfunction

    function automatic logic [W-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[W-1:0];
    endfunction

    function automatic logic [1:0] rand_fwd();
        logic [1:0] v;
        v = 2'($urandom_range(0, 3));
        if (v == 2'd2 && !m_fresh) v = 2'd0;
        return v;
    endfunction

    // ---------------- monitor ----------------
    logic [64:0] snap = '0;
    bit hold_prev = 0;
    bit rst_prev = 1;

    always @(negedge clk) begin
        m_t act;
        m_t e;
        act = '{RegWriteM, MemWriteM, ResultSrcM, RD_M, ALU_ResultM, WriteDataM, PCPlus4M, AuxM};
        if (!rst_prev) begin
            if (hold_prev) begin
                chk("hold_keep", {ValidM, act}, snap);
            end else if (ValidM) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", ValidM, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_stage", act, e);
                end
            end
        end
        snap      = {ValidM, act};
        hold_prev = HoldM;
        rst_prev  = rst;
    end

    // ---------------- driver tasks ----------------
    task automatic issue_alu();
        m_t e;
        logic [W-1:0] a, bf, b, res, tgt;
        bit taken, loaded;
        MulE = 0;
        a      = fwd_ref(RD1_E, ForwardA_E);
        bf     = fwd_ref(RD2_E, ForwardB_E);
        b      = ALUSrcE ? Imm_Ext_E : bf;
        res    = alu_ref(ALUControlE, a, b);
        tgt    = PCE + Imm_Ext_E;
        taken  = ValidE && BranchE && br_ref(BrCondE, a, bf) && !FlushE;
        loaded = ValidE && !FlushE && !HoldM;
        e = '{RegWriteE, MemWriteE, ResultSrcE, RD_E, res, bf, PCPlus4E, AuxE};
        @(negedge clk);
        chk("pcsrc", PCSrcE, taken);
        chk("pctarget", PCTargetE, tgt);
        chk("stall_alu", StallE, 1'b0);
        if (loaded) exp_q.push_back(e);
        @(posedge clk); #1;
        if (!HoldM) begin
            if (loaded) begin
                m_alu = res;
                m_fresh = 1;
            end else begin
                m_fresh = 0;
            end
        end
    endtask

    task automatic rand_ctrl();
        RegWriteE  = 1'($urandom_range(0, 1));
        MemWriteE  = 1'($urandom_range(0, 1));
        ResultSrcE = 1'($urandom_range(0, 1));
        RD_E       = 5'($urandom_range(0, 31));
        AuxE       = 2'($urandom_range(0, 3));
        PCPlus4E   = W'($urandom);
        PCE        = W'($urandom);
        Imm_Ext_E  = W'($urandom);
        ResultW    = W'($urandom);
    endtask

    task automatic rand_alu();
        rand_ctrl();
        ValidE      = ($urandom_range(0, 9) != 0);
        FlushE      = ($urandom_range(0, 9) == 0);
        HoldM       = ($urandom_range(0, 9) == 0);
        BranchE     = 1'($urandom_range(0, 1));
        BrCondE     = 2'($urandom_range(0, 3));
        ALUSrcE     = 1'($urandom_range(0, 1));
        ALUControlE = 3'($urandom_range(0, 7));
        RD1_E       = W'($urandom);
        RD2_E       = ($urandom_range(0, 3) == 0) ? RD1_E : W'($urandom);
        if ($urandom_range(0, 3) == 0) Imm_Ext_E = W'($urandom_range(0, 31));
        ForwardA_E  = rand_fwd();
        ForwardB_E  = rand_fwd();
        issue_alu();
    endtask

    // flush_at < 0 means no flush; hold_n cycles of HoldM while in DONE.
    task automatic issue_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                             input bit rnd_fwd, input int flush_at, input int hold_n);
        m_t e;
        logic [W-1:0] a, bf;
        int stalls;
        bit fin, fl;
        ValidE = 1; MulE = 1; BranchE = 0; FlushE = 0; HoldM = 0;
        ALUSrcE = 1'($urandom_range(0, 1));
        ALUControlE = 3'($urandom_range(0, 7));
        RD1_E = x; RD2_E = y;
        ForwardA_E = rnd_fwd ? rand_fwd() : 2'd0;
        ForwardB_E = rnd_fwd ? rand_fwd() : 2'd0;
        a  = fwd_ref(RD1_E, ForwardA_E);
        bf = fwd_ref(RD2_E, ForwardB_E);
        e  = '{RegWriteE, MemWriteE, ResultSrcE, RD_E, mul_ref(a, bf), bf, PCPlus4E, AuxE};
        stalls = 0; fin = 0; fl = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            FlushE = (c == flush_at);
            HoldM  = (c >= W + 1) && (c < W + 1 + hold_n);
            @(negedge clk);
            if (c >= 1 && c <= W) chk("mul_bubble_valid", ValidM, 1'b0);
            if (StallE) stalls++;
            else fin = 1;
            if (FlushE) begin
                fl = 1;
                fin = 1;
            end else if (!StallE) begin
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        FlushE = 0; HoldM = 0; MulE = 0;
        if (fl) begin
            chk("flush_stall_cnt", stalls, flush_at + 1);
            ValidE = 0;
            @(negedge clk);
            chk("flush_stall_drop", StallE, 1'b0);
            chk("flush_no_valid", ValidM, 1'b0);
            @(posedge clk); #1;
            m_fresh = 0;
        end else begin
            chk("mul_stall_cnt", stalls, W + 1 + hold_n);
            m_alu = e.alu;
            m_fresh = 1;
        end
    endtask

    task automatic idle_check(input string nm, input logic [W-1:0] exp_alu);
        ValidE = 0; MulE = 0; BranchE = 0; FlushE = 0; HoldM = 0;
        @(negedge clk);
        chk(nm, ALU_ResultM, exp_alu);
        chk({nm, "_valid"}, ValidM, 1'b1);
        @(posedge clk); #1;
        m_fresh = 0;
    endtask

    task automatic set_alu(input logic [2:0] op, input logic [W-1:0] r1, input logic [W-1:0] r2,
                           input logic [1:0] fa, input logic [1:0] fb);
        rand_ctrl();
        ValidE = 1; FlushE = 0; HoldM = 0; BranchE = 0; MulE = 0; ALUSrcE = 0;
        RegWriteE = 1;
        ALUControlE = op; RD1_E = r1; RD2_E = r2; ForwardA_E = fa; ForwardB_E = fb;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_m", {ValidM, RegWriteM, MemWriteM, ResultSrcM, RD_M, ALU_ResultM,
                        WriteDataM, PCPlus4M, AuxM}, '0);
        chk("reset_stall", StallE, 1'b0);
        @(posedge clk); #1;

        // add 5 + 7, then sub with forwarding from M (12) and W (3)
        set_alu(3'd0, 18'd5, 18'd7, 2'd0, 2'd0);
        issue_alu();
        set_alu(3'd1, 18'd0, 18'd0, 2'd2, 2'd1);
        ResultW = 18'd3;
        issue_alu();
        idle_check("sub_fwd", 18'd9);

        // branch LT / GE on -1 vs 1; immediate selected for the ALU only
        set_alu(3'd0, 18'h3FFFF, 18'd1, 2'd0, 2'd0);
        BranchE = 1; BrCondE = 2'd2; PCE = 18'h100; Imm_Ext_E = 18'h20; ALUSrcE = 1;
        issue_alu();
        set_alu(3'd0, 18'h3FFFF, 18'd1, 2'd0, 2'd0);
        BranchE = 1; BrCondE = 2'd3; PCE = 18'h100; Imm_Ext_E = 18'h20; ALUSrcE = 1;
        issue_alu();

        // multiply 300 x 7
        rand_ctrl();
        issue_mul(18'd300, 18'd7, 0, -1, 0);
        idle_check("mul_300x7", 18'd2100);

        // flushed multiply, then an add
        rand_ctrl();
        issue_mul(18'd1234, 18'd99, 0, 5, 0);
        set_alu(3'd0, 18'd40, 18'd2, 2'd0, 2'd0);
        issue_alu();

        // HoldM over DONE for 3 cycles
        rand_ctrl();
        issue_mul(18'd513, 18'd77, 0, -1, 3);
        idle_check("mul_hold", 18'((513 * 77) % (1 << W)));

        // reset in the middle of a multiply
        rand_ctrl();
        ValidE = 1; MulE = 1; FlushE = 0; HoldM = 0; BranchE = 0;
        RD1_E = 18'd55; RD2_E = 18'd66; ForwardA_E = 0; ForwardB_E = 0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1; ValidE = 0; MulE = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("midreset_m", {ValidM, RegWriteM, MemWriteM, ResultSrcM, RD_M, ALU_ResultM,
                           WriteDataM, PCPlus4M, AuxM}, '0);
        chk("midreset_stall", StallE, 1'b0);
        @(posedge clk); #1;
        m_fresh = 0;
        set_alu(3'd4, 18'h0F0F0, 18'h00FF0, 2'd0, 2'd0);
        issue_alu();

        // randomized mix
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                rand_ctrl();
                issue_mul(W'($urandom), W'($urandom), 1,
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : -1,
                          int'($urandom_range(0, 2)));
            end else begin
                rand_alu();
            end
        end

        ValidE = 0; MulE = 0; FlushE = 0; HoldM = 0; BranchE = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
